// File: rtl/match_seq_pkg.sv
// Shared types, golden result table and limits for the match-case self-test sequencer.
package match_seq_pkg;

  localparam int unsigned SEL_W    = 8;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned TMR_W    = 4;
  localparam int unsigned GOLDEN_N = 3;

  localparam logic [CNT_W-1:0] ERR_MAX = CNT_W'(255);

  localparam logic [SEL_W-1:0] GOLDEN [GOLDEN_N] = '{8'h00, 8'h02, 8'h03};

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // Expected datapath response; selectors beyond the table expect all-ones.
  function automatic logic [SEL_W-1:0] golden(input logic [SEL_W-1:0] sel);
    golden = 8'hFF;
    for (int unsigned i = 0; i < GOLDEN_N; i++) begin
      if (sel == SEL_W'(i)) golden = GOLDEN[i];
    end
  endfunction

endpackage

// File: rtl/match_seq_settle_timer.sv
// Loadable down-counter that measures the settle time after each selector is driven.
module match_seq_settle_timer
  import match_seq_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/match_case_sequencer.sv
// Self-test sequencer: sweeps selectors into the match datapath and scores results against golden.
// Optional MATCH_SEQ_LOOP_EN: keep re-running sweeps while start_i is held high.
module match_case_sequencer
  import match_seq_pkg::*;
#(
  parameter int unsigned NUM_CASES     = 3,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned WIDTH         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic [WIDTH-1:0] test_case_o,
  input  logic [WIDTH-1:0] result_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [WIDTH-1:0] fail_idx_o
);

  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] LAST_IDX    = WIDTH'(NUM_CASES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] test_case_d;
  logic [CNT_W-1:0] err_d;
  logic [WIDTH-1:0] fail_d;
  logic             pass_d, busy_d, done_d;
  logic             start_q;
  logic             start_rise_c;
  logic             tmr_load, tmr_dec, tmr_zero_c;
  logic [WIDTH-1:0] golden_c;
  logic             mismatch_c;

  assign start_rise_c = start_i & ~start_q;
  assign golden_c     = WIDTH'(golden(SEL_W'(idx_q)));
  assign mismatch_c   = (result_i != golden_c);

  match_seq_settle_timer #(.W(TMR_W)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .dec      (tmr_dec),
    .zero_c   (tmr_zero_c)
  );

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    test_case_d = test_case_o;
    err_d       = err_count_o;
    fail_d      = fail_idx_o;
    pass_d      = pass_o;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_rise_c) begin
          state_d = DRIVE;
          idx_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        test_case_d = idx_q;
        tmr_load    = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (tmr_zero_c) state_d = CHECK;
        else            tmr_dec = 1'b1;
      end
      CHECK: begin
        // err_count==0 marks the first mismatch; saturation leaves fail_idx alone.
        if (mismatch_c) begin
          if (err_count_o == '0)     fail_d = idx_q;
          if (err_count_o != ERR_MAX) err_d = err_count_o + CNT_W'(1);
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + WIDTH'(1);
          state_d = DRIVE;
        end
      end
      DONE: begin
`ifdef MATCH_SEQ_LOOP_EN
        if (start_i) begin
          state_d = DRIVE;
          idx_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRIVE) || (state_d == WAIT) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      start_q     <= 1'b0;
      test_case_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      err_count_o <= '0;
      fail_idx_o  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      start_q     <= start_i;
      test_case_o <= test_case_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      pass_o      <= pass_d;
      err_count_o <= err_d;
      fail_idx_o  <= fail_d;
    end
  end

endmodule

// File: tb/tb_match_case_sequencer.sv
// Self-checking bench for match_case_sequencer against a table-driven sweep model.
module tb_match_case_sequencer;

  localparam int unsigned N   = 3;
  localparam int unsigned S   = 1;
  localparam int unsigned W   = 8;
  localparam int          LAT = N * (2 + S) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] tc;
  logic [W-1:0] res;
  logic         busy, done, pass;
  logic [7:0]   err;
  logic [W-1:0] fidx;

  logic [7:0] resp [0:255];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Behavioural datapath: whatever the response table says for the driven selector.
  assign res = resp[tc];

  match_case_sequencer #(.NUM_CASES(N), .SETTLE_CYCLES(S), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .test_case_o (tc),
    .result_i    (res),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .err_count_o (err),
    .fail_idx_o  (fidx)
  );

  function automatic logic [7:0] ref_gold(input int sel);
    case (sel)
      0:       ref_gold = 8'h00;
      1:       ref_gold = 8'h02;
      2:       ref_gold = 8'h03;
      default: ref_gold = 8'hFF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ideal_table();
    for (int s = 0; s < 256; s++) resp[s] = ref_gold(s);
  endtask

  // One sweep from a negedge; optional extra start pulse at cycle pulse_at.
  task automatic sweep(input int pulse_at);
    int e = 0;
    int f = 0;
    for (int s = 0; s < int'(N); s++) begin
      if (resp[s] !== ref_gold(s)) begin
        if (e == 0) f = s;
        if (e < 255) e++;
      end
    end
    start = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      chk("done_o", 32'(done), 32'(c == LAT));
      chk("busy_o", 32'(busy), 32'(c < LAT));
      if (c == LAT) begin
        chk("pass_o",      32'(pass), 32'(e == 0));
        chk("err_count_o", 32'(err),  32'(e));
        chk("fail_idx_o",  32'(fidx), 32'(f));
        chk("test_case_o", 32'(tc),   32'(N - 1));
      end
      if (c == LAT + 2) begin
        chk("pass_held", 32'(pass), 32'(e == 0));
        chk("tc_held",   32'(tc),   32'(N - 1));
      end
    end
  endtask

  initial begin
    int done_at [$];
    int pulses;
    int last;
    bit expd;

    rst   = 1'b1;
    start = 1'b0;
    ideal_table();
    repeat (3) @(negedge clk);
    chk("rst_tc",   32'(tc),   32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_fidx", 32'(fidx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ideal datapath.
    sweep(0);

    // Single mismatch on selector 1.
    ideal_table();
    resp[1] = 8'h04;
    sweep(0);

    // Every result wrong.
    for (int s = 0; s < 256; s++) resp[s] = 8'hAA;
    sweep(0);

    // Extra start while busy must not restart or shift timing.
    ideal_table();
    resp[2] = 8'h07;
    sweep(4);
`ifndef MATCH_SEQ_LOOP_EN
    // Start in the DONE cycle is ignored in one-shot mode.
    sweep(LAT);
`endif

    // Randomised response tables and stray start pulses.
    for (int it = 0; it < 16; it++) begin
      ideal_table();
      for (int s = 0; s < int'(N); s++) begin
        if ($urandom_range(0, 2) == 0) resp[s] = 8'($urandom);
      end
      sweep(int'($urandom_range(0, LAT - 1)));
    end

    // Reset during WAIT of case 1 with an error already accumulated.
    ideal_table();
    resp[0] = 8'h55;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_tc",  32'(tc),  32'd1);
    chk("pre_rst_err", 32'(err), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tc",   32'(tc),   32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_pass", 32'(pass), 32'd0);
    chk("midrst_err",  32'(err),  32'd0);
    chk("midrst_fidx", 32'(fidx), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    // start_i held high for 15 cycles.
    ideal_table();
    done_at.delete();
    last = LAT;
    done_at.push_back(last);
`ifdef MATCH_SEQ_LOOP_EN
    while (last < 15) begin
      last = last + LAT;
      done_at.push_back(last);
    end
`endif
    pulses = 0;
    start = 1'b1;
    for (int c = 1; c <= last + 6; c++) begin
      @(negedge clk);
      start = (c < 15);
      expd = 1'b0;
      foreach (done_at[k]) if (done_at[k] == c) expd = 1'b1;
      if (done) pulses++;
      chk("hold_done", 32'(done), 32'(expd));
      chk("hold_busy", 32'(busy), 32'(c <= last && !expd));
    end
    chk("hold_pulses", 32'(pulses), 32'(done_at.size()));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
